// File: rtl/keccak_pkg.sv
// rtl/keccak_pkg.sv - shared Keccak engine widths, mode encodings and squeeze FSM states
package keccak_pkg;

  localparam int DWIDTH            = 256;
  localparam int BEAT_BYTES        = DWIDTH / 8;
  localparam int MODE_SEL_WIDTH    = 2;
  localparam int RATE_WIDTH        = 11;
  localparam int BYTE_ABSORB_WIDTH = 8;

  localparam logic [MODE_SEL_WIDTH-1:0] MODE_SHA3_256 = 2'd0;
  localparam logic [MODE_SEL_WIDTH-1:0] MODE_SHA3_512 = 2'd1;
  localparam logic [MODE_SEL_WIDTH-1:0] MODE_SHAKE128 = 2'd2;
  localparam logic [MODE_SEL_WIDTH-1:0] MODE_SHAKE256 = 2'd3;

  typedef enum logic [1:0] {
    SQ_IDLE,
    SQ_SQUEEZE,
    SQ_PERM_REQ,
    SQ_PERM_WAIT
  } squeeze_state_t;

  // XOF modes are the only ones with a programmable length or an external stop
  function automatic logic is_shake(input logic [MODE_SEL_WIDTH-1:0] mode);
    return (mode == MODE_SHAKE128) || (mode == MODE_SHAKE256);
  endfunction

endpackage

// File: rtl/keccak_squeeze_ctrl.sv
// rtl/keccak_squeeze_ctrl.sv - squeeze-phase sequencer: beat handshake, re-permutation and termination
module keccak_squeeze_ctrl
  import keccak_pkg::*;
#(
  parameter int XOF_LEN_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start_i,
  input  logic [MODE_SEL_WIDTH-1:0]    keccak_mode_i,
  input  logic [RATE_WIDTH-1:0]        rate_i,
  input  logic [XOF_LEN_WIDTH-1:0]     xof_len_i,
  input  logic                         stop_i,
  input  logic [BYTE_ABSORB_WIDTH-1:0] ou_bytes_next_i,
  input  logic                         ou_perm_needed_i,
  input  logic [BEAT_BYTES-1:0]        ou_keep_i,
  input  logic                         ou_last_i,
  output logic [BYTE_ABSORB_WIDTH-1:0] bytes_squeezed_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [BEAT_BYTES-1:0]        out_keep_o,
  output logic                         out_last_o,
  output logic                         perm_req_o,
  input  logic                         perm_done_i,
  output logic                         busy_o,
  output logic                         done_o
);

  localparam int RB_WIDTH = RATE_WIDTH - 3;

  squeeze_state_t               state_q, state_d;
  logic [MODE_SEL_WIDTH-1:0]    mode_q, mode_d;
  logic [RB_WIDTH-1:0]          rate_bytes_q, rate_bytes_d;
  logic [XOF_LEN_WIDTH-1:0]     xof_len_q, xof_len_d;
  logic [BYTE_ABSORB_WIDTH-1:0] cnt_q, cnt_d;
  logic [XOF_LEN_WIDTH-1:0]     total_q, total_d;
  logic                         stop_pend_q, stop_pend_d;
  logic                         done_q, done_d;

  logic                         shake_q;
  logic [XOF_LEN_WIDTH-1:0]     beat_bytes;
  logic [XOF_LEN_WIDTH-1:0]     len_rem;
  logic [XOF_LEN_WIDTH:0]       total_sum;
  logic [XOF_LEN_WIDTH-1:0]     total_sat;
  logic                         len_hit;
  logic                         last_beat;
  logic                         accept;
  logic                         unused_rate_bits;

  // Rate is always a whole number of bytes; the sub-byte bits carry no information
  assign unused_rate_bits = ^rate_i[2:0];

  // Keep only the lowest n bytes of a beat
  function automatic logic [BEAT_BYTES-1:0] low_mask(input logic [XOF_LEN_WIDTH-1:0] n);
    logic [BEAT_BYTES-1:0] m;
    for (int i = 0; i < BEAT_BYTES; i++) begin
      m[i] = (XOF_LEN_WIDTH'(i) < n);
    end
    return m;
  endfunction

  assign shake_q    = is_shake(mode_q);
  // A rate-draining beat only carries what is left of the rate block
  assign beat_bytes = ou_perm_needed_i
                    ? (XOF_LEN_WIDTH'(rate_bytes_q) - XOF_LEN_WIDTH'(cnt_q))
                    : XOF_LEN_WIDTH'(BEAT_BYTES);
  assign len_rem    = xof_len_q - total_q;
  assign len_hit    = shake_q && (xof_len_q != '0) && (len_rem <= beat_bytes);
  assign last_beat  = (!shake_q && ou_last_i) || len_hit || stop_pend_q;
  assign total_sum  = {1'b0, total_q} + {1'b0, beat_bytes};
  assign total_sat  = total_sum[XOF_LEN_WIDTH] ? '1 : total_sum[XOF_LEN_WIDTH-1:0];

  assign out_valid_o      = (state_q == SQ_SQUEEZE);
  assign accept           = out_valid_o && out_ready_i;
  assign out_keep_o       = !out_valid_o ? '0 : (len_hit ? (ou_keep_i & low_mask(len_rem)) : ou_keep_i);
  assign out_last_o       = out_valid_o && last_beat;
  assign bytes_squeezed_o = cnt_q;
  assign perm_req_o       = (state_q == SQ_PERM_REQ);
  assign busy_o           = (state_q != SQ_IDLE);
  assign done_o           = done_q;

  // Next-state: stream sequencing, counters and stop bookkeeping
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    rate_bytes_d = rate_bytes_q;
    xof_len_d    = xof_len_q;
    cnt_d        = cnt_q;
    total_d      = total_q;
    stop_pend_d  = stop_pend_q;
    done_d       = 1'b0;

    if (state_q != SQ_IDLE && shake_q && stop_i) begin
      stop_pend_d = 1'b1;
    end

    case (state_q)
      SQ_IDLE: begin
        if (start_i) begin
          mode_d       = keccak_mode_i;
          rate_bytes_d = rate_i[RATE_WIDTH-1:3];
          xof_len_d    = xof_len_i;
          cnt_d        = '0;
          total_d      = '0;
          stop_pend_d  = 1'b0;
          state_d      = SQ_SQUEEZE;
        end
      end
      SQ_SQUEEZE: begin
        if (accept) begin
          total_d = total_sat;
          if (last_beat) begin
            // Last beat takes priority over a rate drain on the same beat
            state_d     = SQ_IDLE;
            done_d      = 1'b1;
            stop_pend_d = 1'b0;
          end else if (ou_perm_needed_i) begin
            state_d = SQ_PERM_REQ;
          end else begin
            cnt_d = ou_bytes_next_i;
          end
        end
      end
      SQ_PERM_REQ: begin
        cnt_d   = '0;
        state_d = SQ_PERM_WAIT;
      end
      SQ_PERM_WAIT: begin
        if (perm_done_i) begin
          if (stop_pend_q) begin
            state_d     = SQ_IDLE;
            done_d      = 1'b1;
            stop_pend_d = 1'b0;
          end else begin
            state_d = SQ_SQUEEZE;
          end
        end
      end
      default: state_d = SQ_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= SQ_IDLE;
      mode_q       <= '0;
      rate_bytes_q <= '0;
      xof_len_q    <= '0;
      cnt_q        <= '0;
      total_q      <= '0;
      stop_pend_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      rate_bytes_q <= rate_bytes_d;
      xof_len_q    <= xof_len_d;
      cnt_q        <= cnt_d;
      total_q      <= total_d;
      stop_pend_q  <= stop_pend_d;
      done_q       <= done_d;
    end
  end

endmodule

// File: tb/tb_keccak_squeeze_ctrl.sv
// tb/tb_keccak_squeeze_ctrl.sv - scoreboard bench for the squeeze sequencer with an output-unit model
module tb_keccak_squeeze_ctrl;
  import keccak_pkg::*;

  localparam int XW = 16;

  logic                         clk = 1'b0;
  logic                         rst_n = 1'b0;
  logic                         start_i = 1'b0;
  logic [MODE_SEL_WIDTH-1:0]    keccak_mode_i = '0;
  logic [RATE_WIDTH-1:0]        rate_i = '0;
  logic [XW-1:0]                xof_len_i = '0;
  logic                         stop_i = 1'b0;
  logic [BYTE_ABSORB_WIDTH-1:0] ou_bytes_next_i;
  logic                         ou_perm_needed_i;
  logic [BEAT_BYTES-1:0]        ou_keep_i;
  logic                         ou_last_i;
  logic [BYTE_ABSORB_WIDTH-1:0] bytes_squeezed_o;
  logic                         out_valid_o;
  logic                         out_ready_i = 1'b0;
  logic [BEAT_BYTES-1:0]        out_keep_o;
  logic                         out_last_o;
  logic                         perm_req_o;
  logic                         perm_done_i = 1'b0;
  logic                         busy_o;
  logic                         done_o;

  typedef struct {
    logic [7:0]  cnt;
    logic [31:0] keep;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    tests_run = 0;
  int    tests_failed = 0;
  int    beats = 0;
  int    perm_cnt = 0;
  int    done_cnt = 0;
  int    perm_delay = 0;
  bit    auto_perm = 1'b1;
  bit    stall_prev = 1'b0;
  logic [7:0]  st_cnt;
  logic [31:0] st_keep;
  logic        st_last;

  keccak_squeeze_ctrl #(.XOF_LEN_WIDTH(XW)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .keccak_mode_i(keccak_mode_i),
    .rate_i(rate_i), .xof_len_i(xof_len_i), .stop_i(stop_i),
    .ou_bytes_next_i(ou_bytes_next_i), .ou_perm_needed_i(ou_perm_needed_i),
    .ou_keep_i(ou_keep_i), .ou_last_i(ou_last_i), .bytes_squeezed_o(bytes_squeezed_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_keep_o(out_keep_o),
    .out_last_o(out_last_o), .perm_req_o(perm_req_o), .perm_done_i(perm_done_i),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] tb_mask(input int n);
    logic [31:0] m;
    for (int i = 0; i < 32; i++) m[i] = (i < n);
    return m;
  endfunction

  // Output unit stand-in: counter-driven keep/last/drain flags
  int ou_rb, ou_cnt, ou_dig;
  always_comb begin
    ou_rb  = int'(rate_i[RATE_WIDTH-1:3]);
    ou_cnt = int'(bytes_squeezed_o);
    ou_dig = (keccak_mode_i == MODE_SHA3_512) ? 64 : 32;
    ou_bytes_next_i = bytes_squeezed_o + 8'd32;
    if (is_shake(keccak_mode_i)) begin
      ou_last_i        = 1'b0;
      ou_perm_needed_i = (ou_cnt + 32 >= ou_rb);
      ou_keep_i        = ou_perm_needed_i ? tb_mask(ou_rb - ou_cnt) : 32'hFFFF_FFFF;
    end else begin
      ou_perm_needed_i = 1'b0;
      ou_last_i        = (ou_cnt + 32 >= ou_dig);
      ou_keep_i        = 32'hFFFF_FFFF;
    end
  end

  function automatic beat_t mk(input int cnt, input logic [31:0] keep, input logic last);
    beat_t b;
    b.cnt = 8'(cnt); b.keep = keep; b.last = last;
    return b;
  endfunction

  // One clock: sample at negedge, pop scoreboard on accepted beats, then step past posedge
  task automatic tick();
    beat_t e;
    @(negedge clk);
    if (rst_n) begin
      if (perm_req_o) begin
        perm_cnt++;
        if (auto_perm) perm_delay = 2;
      end
      if (done_o) done_cnt++;
      if (stall_prev && out_valid_o) begin
        tests_run++;
        if (bytes_squeezed_o !== st_cnt || out_keep_o !== st_keep || out_last_o !== st_last) begin
          tests_failed++;
          $display("FAIL stall_stable: cnt=%0d keep=%h last=%b required cnt=%0d keep=%h last=%b",
                   bytes_squeezed_o, out_keep_o, out_last_o, st_cnt, st_keep, st_last);
        end
      end
      stall_prev = out_valid_o && !out_ready_i;
      st_cnt = bytes_squeezed_o; st_keep = out_keep_o; st_last = out_last_o;
      if (out_valid_o && out_ready_i) begin
        tests_run++;
        beats++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL unexpected_beat: cnt=%0d keep=%h last=%b required no beat",
                   bytes_squeezed_o, out_keep_o, out_last_o);
        end else begin
          e = exp_q.pop_front();
          if (bytes_squeezed_o !== e.cnt || out_keep_o !== e.keep || out_last_o !== e.last) begin
            tests_failed++;
            $display("FAIL beat: cnt=%0d keep=%h last=%b required cnt=%0d keep=%h last=%b",
                     bytes_squeezed_o, out_keep_o, out_last_o, e.cnt, e.keep, e.last);
          end
        end
      end
    end
    @(posedge clk);
    #1;
    perm_done_i = 1'b0;
    if (perm_delay > 0) begin
      perm_delay--;
      if (perm_delay == 0) perm_done_i = 1'b1;
    end
  endtask

  task automatic do_start(input logic [1:0] mode, input int rate, input int xof);
    keccak_mode_i = mode; rate_i = RATE_WIDTH'(rate); xof_len_i = XW'(xof);
    beats = 0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic run_until_done(input string name, input int budget, input bit toggle);
    int n = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && n < budget) begin
      out_ready_i = toggle ? (n % 2 == 1) : 1'b1;
      tick();
      n++;
    end
    out_ready_i = 1'b1;
    tests_run++;
    if (done_cnt != d0 + 1 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL %s_done: done_pulses=%0d pending_beats=%0d required done_pulses=1 pending_beats=0",
               name, done_cnt - d0, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    #2;
    tests_run++;
    if ({out_valid_o, out_keep_o, out_last_o, perm_req_o, busy_o, done_o, bytes_squeezed_o} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: valid=%b keep=%h last=%b req=%b busy=%b done=%b cnt=%0d required all 0",
               out_valid_o, out_keep_o, out_last_o, perm_req_o, busy_o, done_o, bytes_squeezed_o);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    tick();
    tests_run++;
    if (busy_o !== 1'b0 || out_valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_after_reset: busy=%b valid=%b required 0 0", busy_o, out_valid_o);
    end
  endtask

  task automatic test_sha3_256();
    int p0 = perm_cnt;
    exp_q.push_back(mk(0, 32'hFFFF_FFFF, 1'b1));
    do_start(MODE_SHA3_256, 1088, 0);
    run_until_done("sha3_256", 20, 1'b0);
    tests_run++;
    if (perm_cnt != p0 || beats != 1) begin
      tests_failed++;
      $display("FAIL sha3_256_perm: perm_req=%0d beats=%0d required 0 1", perm_cnt - p0, beats);
    end
  endtask

  task automatic test_sha3_512_stall();
    exp_q.push_back(mk(0, 32'hFFFF_FFFF, 1'b0));
    exp_q.push_back(mk(32, 32'hFFFF_FFFF, 1'b1));
    do_start(MODE_SHA3_512, 576, 0);
    out_ready_i = 1'b1; stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    run_until_done("sha3_512", 20, 1'b1);
  endtask

  task automatic test_shake128_unbounded_stop();
    int n = 0;
    int p0 = perm_cnt;
    for (int i = 0; i < 5; i++) exp_q.push_back(mk(32 * i, 32'hFFFF_FFFF, 1'b0));
    exp_q.push_back(mk(160, 32'h0000_00FF, 1'b0));
    exp_q.push_back(mk(0, 32'hFFFF_FFFF, 1'b0));
    exp_q.push_back(mk(32, 32'hFFFF_FFFF, 1'b1));
    out_ready_i = 1'b1;
    do_start(MODE_SHAKE128, 1344, 0);
    while (beats < 6 && n < 100) begin tick(); n++; end
    out_ready_i = 1'b0;
    while (!out_valid_o && n < 200) begin tick(); n++; end
    out_ready_i = 1'b1; stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    run_until_done("shake128_stop", 20, 1'b0);
    tests_run++;
    if (perm_cnt - p0 != 1 || beats != 8) begin
      tests_failed++;
      $display("FAIL shake128_perm: perm_req=%0d beats=%0d required 1 8", perm_cnt - p0, beats);
    end
  endtask

  task automatic test_shake256_xof40();
    int p0 = perm_cnt;
    exp_q.push_back(mk(0, 32'hFFFF_FFFF, 1'b0));
    exp_q.push_back(mk(32, 32'h0000_00FF, 1'b1));
    out_ready_i = 1'b1;
    do_start(MODE_SHAKE256, 1088, 40);
    run_until_done("shake256_xof40", 20, 1'b0);
    tests_run++;
    if (perm_cnt != p0) begin
      tests_failed++;
      $display("FAIL shake256_xof40_perm: perm_req=%0d required 0", perm_cnt - p0);
    end
  endtask

  task automatic test_len_hit_with_drain();
    int p0 = perm_cnt;
    for (int i = 0; i < 5; i++) exp_q.push_back(mk(32 * i, 32'hFFFF_FFFF, 1'b0));
    exp_q.push_back(mk(160, 32'h0000_00FF, 1'b1));
    out_ready_i = 1'b1;
    do_start(MODE_SHAKE128, 1344, 168);
    run_until_done("len_hit_drain", 40, 1'b0);
    tests_run++;
    if (perm_cnt != p0) begin
      tests_failed++;
      $display("FAIL len_hit_drain_perm: perm_req=%0d required 0", perm_cnt - p0);
    end
  endtask

  task automatic test_stop_in_perm_wait();
    int n = 0;
    int p0 = perm_cnt;
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(32 * i, 32'hFFFF_FFFF, 1'b0));
    exp_q.push_back(mk(128, 32'h0000_00FF, 1'b0));
    out_ready_i = 1'b1;
    do_start(MODE_SHAKE256, 1088, 0);
    while (perm_cnt == p0 && n < 100) begin tick(); n++; end
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    run_until_done("stop_perm_wait", 20, 1'b0);
    tests_run++;
    if (beats != 5 || perm_cnt - p0 != 1) begin
      tests_failed++;
      $display("FAIL stop_perm_wait_beats: beats=%0d perm_req=%0d required 5 1", beats, perm_cnt - p0);
    end
  endtask

  task automatic test_async_reset_mid_squeeze();
    int n = 0;
    int d0 = done_cnt;
    exp_q.push_back(mk(0, 32'hFFFF_FFFF, 1'b0));
    exp_q.push_back(mk(32, 32'hFFFF_FFFF, 1'b0));
    out_ready_i = 1'b1;
    do_start(MODE_SHAKE128, 1344, 0);
    while (beats < 2 && n < 50) begin tick(); n++; end
    rst_n = 1'b0;
    #2;
    tests_run++;
    if ({out_valid_o, out_keep_o, out_last_o, busy_o, bytes_squeezed_o} !== '0) begin
      tests_failed++;
      $display("FAIL mid_reset_outputs: valid=%b keep=%h last=%b busy=%b cnt=%0d required all 0",
               out_valid_o, out_keep_o, out_last_o, busy_o, bytes_squeezed_o);
    end
    stall_prev = 1'b0;
    perm_delay = 0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (done_cnt != d0 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL mid_reset_done: done_pulses=%0d pending=%0d required 0 0", done_cnt - d0, exp_q.size());
      exp_q.delete();
    end
    exp_q.push_back(mk(0, 32'hFFFF_FFFF, 1'b1));
    do_start(MODE_SHA3_256, 1088, 0);
    run_until_done("restart_after_reset", 20, 1'b0);
  endtask

  initial begin
    test_reset();
    test_sha3_256();
    test_sha3_512_stall();
    test_shake128_unbounded_stop();
    test_shake256_xof40();
    test_len_hit_with_drain();
    test_stop_in_perm_wait();
    test_async_reset_mid_squeeze();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/keccak_squeeze_ctrl.md
Name: keccak_squeeze_ctrl

Overview:
Sequences the squeeze phase of the Keccak sponge. It drives the squeeze byte counter into the combinational output unit and presents each extracted window as a valid/ready output beat. It requests re-permutation from the core FSM when the rate block is drained, and terminates on fixed digest length, on a programmed XOF length, or on an external stop. It sits between the permutation core/top FSM and the engine's output stream port.

Parameters:
DWIDTH, 256 (keccak_pkg), output beat width in bits; beat is DWIDTH/8 bytes
XOF_LEN_WIDTH, 16, width of the programmable SHAKE output length in bytes

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start_i  in  1  pulse: final absorb permutation complete, begin squeezing
keccak_mode_i  in  MODE_SEL_WIDTH  SHA3_256/SHA3_512/SHAKE128/SHAKE256; sampled at start_i
rate_i  in  RATE_WIDTH  rate in bits; sampled at start_i
xof_len_i  in  XOF_LEN_WIDTH  SHAKE output bytes, 0 = unbounded; sampled at start_i
stop_i  in  1  pulse: terminate XOF stream
ou_bytes_next_i  in  BYTE_ABSORB_WIDTH  output unit next-counter value
ou_perm_needed_i  in  1  output unit rate-drained flag
ou_keep_i  in  DWIDTH/8  output unit byte-valid mask
ou_last_i  in  1  output unit fixed-length last flag
bytes_squeezed_o  out  BYTE_ABSORB_WIDTH  counter to output unit
out_valid_o  out  1  beat valid
out_ready_i  in  1  downstream ready
out_keep_o  out  DWIDTH/8  final byte mask of beat
out_last_o  out  1  final beat of digest/stream
perm_req_o  out  1  one-cycle pulse: permute state for next squeeze block
perm_done_i  in  1  pulse: requested permutation complete
busy_o  out  1  state != IDLE
done_o  out  1  one-cycle pulse when squeeze ends

Behaviour:
- Reset (async, rst_n=0): state IDLE; bytes_squeezed_o=0; total byte count=0; stop_pend=0; all outputs 0. A mid-operation reset abandons the stream with no last/done.
- States: IDLE, SQUEEZE, PERM_REQ, PERM_WAIT.
- IDLE: on start_i, latch mode/rate/xof_len, clear counters, go to SQUEEZE. start_i is ignored outside IDLE.
- SQUEEZE: out_valid_o=1 combinationally; data is valid the first cycle in the state (0-cycle latency through the output unit).
- Beat bytes: beat_bytes = ou_perm_needed_i ? (rate_i/8 - bytes_squeezed_o) : DWIDTH/8.
- len_rem = xof_len - total. len_hit = SHAKE mode & xof_len != 0 & len_rem <= beat_bytes.
- out_keep_o = len_hit ? ou_keep_i & ((1<<len_rem)-1) : ou_keep_i.
- out_last_o = ou_last_i (SHA3 modes only) | len_hit | stop_pend.
- Handshake: valid, keep and last are held stable until out_valid_o&out_ready_i. The counter never advances without acceptance.
- On accept:
  - If last: go to IDLE, pulse done_o, clear stop_pend.
  - Else if ou_perm_needed_i: go to PERM_REQ.
  - Else: bytes_squeezed_o <= ou_bytes_next_i and total += DWIDTH/8.
  - total adds beat_bytes in all cases and saturates at all-ones.
- PERM_REQ: perm_req_o=1 for exactly one cycle, bytes_squeezed_o <= 0, go to PERM_WAIT.
- PERM_WAIT: on perm_done_i:
  - If stop_pend: go to IDLE, pulse done_o, emit no beat.
  - Else: go to SQUEEZE.
  - perm_done_i in any other state is ignored.
- stop_i:
  - Sets stop_pend in SQUEEZE/PERM_REQ/PERM_WAIT for SHAKE modes.
  - In SHA3 modes it is ignored, and it is ignored in IDLE.
  - stop_i in the same cycle as an accept of a non-last beat marks the next beat last. The accepted beat is not retroactively changed.
- Simultaneous len_hit and ou_perm_needed_i on an accepted beat: last wins, no perm_req_o.
- SHA3 modes never reach PERM_REQ, since digest < rate.

Decomposition:
- keccak_pkg gains typedef squeeze_state_t (IDLE, SQUEEZE, PERM_REQ, PERM_WAIT) and constant BEAT_BYTES = DWIDTH/8.
- Reuses the existing MODE_SEL_WIDTH, RATE_WIDTH, BYTE_ABSORB_WIDTH and mode encodings from keccak_pkg.
- No sub-module. The byte-mask generator is a local function.
- The top level instantiates this block beside keccak_output_unit.

Test Plan:
- SHA3_256, rate 1088, ready=1: one beat, keep=0xFFFFFFFF, last=1, done_o next cycle, perm_req_o never asserted.
- SHA3_512, rate 576, ready toggling 1-0-1: two beats at counter 0 and 32, last on second, data/keep stable across stalled cycles.
- SHAKE128, rate 1344 (168 B), xof_len=0, ready=1:
  - Beats 1-5 have full keep at counter 0..128.
  - Beat 6 has keep=0xFF at counter 160.
  - perm_req_o pulses, then after perm_done_i the counter restarts at 0.
  - stop_i then yields last on the next beat.
- SHAKE256, rate 1088, xof_len=40: beat 1 full keep; beat 2 keep=0x000000FF, last=1, no perm_req_o.
- SHAKE128, xof_len=168: beat 6 has len_hit and perm_needed together -> last=1, keep=0xFF, no perm_req_o.
- Stop and reset corner cases:
  - stop_i during PERM_WAIT -> after perm_done_i, done_o pulses with no further beat.
  - rst_n low mid-SQUEEZE -> all outputs 0 immediately; a later start_i restarts at counter 0.
